// File: rtl/dec_gpr_ctx_ctl.sv
// ---------------------------------------------------------------------------
// dec_gpr_ctx_ctl
//
// Purpose:
//   Context-switch controller for a banked GPR file. On request it selects a
//   target bank, then either streams x1..x31 of that bank out (save) or
//   streams 31 words in and writes them to x1..x31 (restore). Afterwards it
//   re-selects the bank that was active when the request was accepted, and
//   pulses done (with aborted set if the transfer was cut short).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   save_req_i               start a save of req_bank_i (sampled in IDLE only)
//   restore_req_i            start a restore into req_bank_i (IDLE only)
//   req_bank_i, cur_bank_i   target / currently active bank, latched on accept
//   abort_i                  terminate an active SAVE or RESTORE
//   busy_o                   high in every state except IDLE
//   done_o, aborted_o        one-cycle completion pulse and its abort flag
//   gpr_wen_bank_id_o        bank-select register write enable
//   gpr_wr_bank_id_o         bank-select register write value
//   gpr_rden_o, gpr_raddr_o  register-file read port (gpr_rd_i comb. return)
//   gpr_wen_o, gpr_waddr_o,
//   gpr_wd_o                 register-file write port (written next edge)
//   so_valid_o/so_ready_i/
//   so_data_o/so_idx_o       save stream out
//   si_valid_i/si_ready_o/
//   si_data_i                restore stream in
// ---------------------------------------------------------------------------
module dec_gpr_ctx_ctl #(
  parameter int XLEN           = 64,
  parameter int GPR_BANKS_LOG2 = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      save_req_i,
  input  logic                      restore_req_i,
  input  logic [GPR_BANKS_LOG2-1:0] req_bank_i,
  input  logic [GPR_BANKS_LOG2-1:0] cur_bank_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      aborted_o,
  output logic                      gpr_wen_bank_id_o,
  output logic [GPR_BANKS_LOG2-1:0] gpr_wr_bank_id_o,
  output logic                      gpr_rden_o,
  output logic [4:0]                gpr_raddr_o,
  input  logic [XLEN-1:0]           gpr_rd_i,
  output logic                      gpr_wen_o,
  output logic [4:0]                gpr_waddr_o,
  output logic [XLEN-1:0]           gpr_wd_o,
  output logic                      so_valid_o,
  input  logic                      so_ready_i,
  output logic [XLEN-1:0]           so_data_o,
  output logic [4:0]                so_idx_o,
  input  logic                      si_valid_i,
  output logic                      si_ready_o,
  input  logic [XLEN-1:0]           si_data_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELBANK   = 3'd1,
    SETTLE    = 3'd2,
    SAVE      = 3'd3,
    RESTORE   = 3'd4,
    RETBANK   = 3'd5,
    RETSETTLE = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam logic [4:0] IDX_FIRST = 5'd1;
  localparam logic [4:0] IDX_LAST  = 5'd31;

  state_t                    state_q, state_d;
  logic [4:0]                idx_q, idx_d;
  logic                      flag_q, flag_d;
  logic                      save_mode_q, save_mode_d;
  logic [GPR_BANKS_LOG2-1:0] req_bank_q, req_bank_d;
  logic [GPR_BANKS_LOG2-1:0] cur_bank_q, cur_bank_d;

  // Output registers decoded from the next state, so every state-only output
  // comes straight from a flop.
  logic                      busy_q;
  logic                      done_q;
  logic                      aborted_q;
  logic                      bsel_wen_q;
  logic [GPR_BANKS_LOG2-1:0] bsel_id_q;
  logic                      save_act_q;
  logic                      rest_act_q;

  logic save_hs;
  logic rest_hs;

  // so_valid is high throughout SAVE and si_ready throughout RESTORE, so a
  // handshake only needs the partner's signal.
  assign save_hs = save_act_q & so_ready_i;
  assign rest_hs = rest_act_q & si_valid_i;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    flag_d      = flag_q;
    save_mode_d = save_mode_q;
    req_bank_d  = req_bank_q;
    cur_bank_d  = cur_bank_q;
    unique case (state_q)
      IDLE: begin
        if (save_req_i || restore_req_i) begin
          state_d     = SELBANK;
          save_mode_d = save_req_i;   // save wins when both are requested
          req_bank_d  = req_bank_i;
          cur_bank_d  = cur_bank_i;
          flag_d      = 1'b0;
        end
      end
      SELBANK: state_d = SETTLE;
      SETTLE: begin
        // One bubble so the freshly written bank id is in effect before the
        // first register-file access.
        idx_d   = IDX_FIRST;
        state_d = save_mode_q ? SAVE : RESTORE;
      end
      SAVE: begin
        // idx stops at 31 instead of wrapping: x0 is never touched.
        if (save_hs && (idx_q != IDX_LAST)) idx_d = idx_q + 5'd1;
        if (abort_i) begin
          flag_d  = 1'b1;
          state_d = RETBANK;
        end else if (save_hs && (idx_q == IDX_LAST)) begin
          state_d = RETBANK;
        end
      end
      RESTORE: begin
        // A beat that coincides with abort is still written (gpr_wen is
        // combinational on the handshake).
        if (rest_hs && (idx_q != IDX_LAST)) idx_d = idx_q + 5'd1;
        if (abort_i) begin
          flag_d  = 1'b1;
          state_d = RETBANK;
        end else if (rest_hs && (idx_q == IDX_LAST)) begin
          state_d = RETBANK;
        end
      end
      RETBANK:   state_d = RETSETTLE;
      RETSETTLE: state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= IDX_FIRST;
      flag_q      <= 1'b0;
      save_mode_q <= 1'b0;
      req_bank_q  <= '0;
      cur_bank_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      bsel_wen_q  <= 1'b0;
      bsel_id_q   <= '0;
      save_act_q  <= 1'b0;
      rest_act_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      flag_q      <= flag_d;
      save_mode_q <= save_mode_d;
      req_bank_q  <= req_bank_d;
      cur_bank_q  <= cur_bank_d;
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
      aborted_q   <= (state_d == DONE) && flag_d;
      bsel_wen_q  <= (state_d == SELBANK) || (state_d == RETBANK);
      if (state_d == SELBANK)      bsel_id_q <= req_bank_d;
      else if (state_d == RETBANK) bsel_id_q <= cur_bank_d;
      else                         bsel_id_q <= '0;
      save_act_q  <= (state_d == SAVE);
      rest_act_q  <= (state_d == RESTORE);
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign aborted_o         = aborted_q;
  assign gpr_wen_bank_id_o = bsel_wen_q;
  assign gpr_wr_bank_id_o  = bsel_id_q;

  // Save side: read data flows through combinationally; idx only moves on a
  // handshake, so data and index hold steady under backpressure.
  assign gpr_rden_o  = save_act_q;
  assign so_valid_o  = save_act_q;
  assign gpr_raddr_o = save_act_q ? idx_q : 5'd0;
  assign so_idx_o    = save_act_q ? idx_q : 5'd0;
  assign so_data_o   = save_act_q ? gpr_rd_i : '0;

  // Restore side: each accepted beat is written in the same cycle.
  assign si_ready_o  = rest_act_q;
  assign gpr_wen_o   = rest_hs;
  assign gpr_waddr_o = rest_hs ? idx_q : 5'd0;
  assign gpr_wd_o    = rest_hs ? si_data_i : '0;

endmodule
